// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches on the program
// memory bus with a bounded number of reads in flight, buffers the returned
// words with their PCs and hands them to decode over valid/ready. A redirect
// flushes the buffer and discards every response that is still in flight.
module instruction_prefetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h00400000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        bus_read_enable,
    output logic [31:0] bus_address,
    input  logic        bus_wait_req,
    input  logic        bus_valid,
    input  logic [31:0] bus_read_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] DEPTH_U   = QUEUE_DEPTH;
    localparam logic [31:0] MAX_OUT_U = MAX_OUTSTANDING;

    // Control state
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_count_q, drop_count_d;
    logic [CNT_W-1:0] occupancy_q, occupancy_d;
    logic             valid_q, valid_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    // Instruction storage (data only, never reset)
    logic [31:0] data_mem_q [QUEUE_DEPTH];
    logic [31:0] pc_mem_q   [QUEUE_DEPTH];

    logic issue, accept, resp_ok, push, pop, mem_we;

    // Low address bits of the redirect target are forced to zero.
    logic redirect_pc_unused;
    assign redirect_pc_unused = ^redirect_pc[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(QUEUE_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Issue/accept, credit accounting, response filtering and FIFO next-state
    always_comb begin
        issue   = !reset && !redirect
                  && ({{(32-OUT_W){1'b0}}, outstanding_q} < MAX_OUT_U)
                  && (({{(32-OUT_W){1'b0}}, outstanding_q}
                       + {{(32-CNT_W){1'b0}}, occupancy_q}) < DEPTH_U);
        accept  = issue && !bus_wait_req;
        // A response with nothing outstanding is a bus protocol error; ignore it.
        resp_ok = bus_valid && (outstanding_q != '0);
        push    = resp_ok && (drop_count_q == '0);
        pop     = valid_q && inst_ready;
        mem_we  = push && !redirect && !reset;

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_count_d  = drop_count_q;
        occupancy_d   = occupancy_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        case ({accept, resp_ok})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect) begin
            // Everything still in flight (minus the response landing now,
            // which is itself discarded) must be dropped when it returns.
            fetch_pc_d   = {redirect_pc[31:2], 2'b00};
            resp_pc_d    = {redirect_pc[31:2], 2'b00};
            drop_count_d = outstanding_q - OUT_W'(resp_ok);
            occupancy_d  = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            if (resp_ok) begin
                if (drop_count_q != '0) begin
                    drop_count_d = drop_count_q - OUT_W'(1);
                end else begin
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   occupancy_d = occupancy_q + CNT_W'(1);
                2'b01:   occupancy_d = occupancy_q - CNT_W'(1);
                default: occupancy_d = occupancy_q;
            endcase
        end

        valid_d = (occupancy_d != '0);
    end

    // Control registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_count_q  <= '0;
            occupancy_q   <= '0;
            valid_q       <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            occupancy_q   <= occupancy_d;
            valid_q       <= valid_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Write accepted responses with their PC into the tail slot
    always_ff @(posedge clock) begin
        if (mem_we) begin
            data_mem_q[wr_ptr_q] <= bus_read_data;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    assign bus_read_enable = issue;
    assign bus_address     = fetch_pc_q;
    assign inst_valid      = valid_q;
    assign inst            = data_mem_q[rd_ptr_q];
    assign inst_pc         = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue with an in-order bus model
// of configurable latency whose word at address A is A>>2.
module tb_instruction_prefetch_queue;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic        clock;
    logic        reset;
    logic        bus_read_enable;
    logic [31:0] bus_address;
    logic        bus_wait_req;
    logic        bus_valid;
    logic [31:0] bus_read_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    instruction_prefetch_queue #(
        .RESET_PC        (RESET_PC),
        .QUEUE_DEPTH     (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .bus_read_enable (bus_read_enable),
        .bus_address     (bus_address),
        .bus_wait_req    (bus_wait_req),
        .bus_valid       (bus_valid),
        .bus_read_data   (bus_read_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          waited;
    logic [31:0] exp_pc = RESET_PC;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // One clock: sample at negedge (scoreboard pops), then advance the bus model.
    task automatic tick();
        logic        acc, rv, rst, rdr;
        logic [31:0] addr;
        req_t        r;
        @(negedge clock);
        acc  = bus_read_enable && !bus_wait_req;
        addr = bus_address;
        rv   = bus_valid;
        rst  = reset;
        rdr  = redirect;
        if (rst) begin
            exp_pc = RESET_PC;
        end else if (rdr) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else if (inst_valid && inst_ready) begin
            check_eq("pop_pc", inst_pc, exp_pc);
            check_eq("pop_inst", inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pop_cnt++;
        end
        if (acc) acc_cnt++;
        @(posedge clock);
        #1;
        cyc++;
        if (rst) begin
            pend.delete();
        end else begin
            if (rv && pend.size() > 0) void'(pend.pop_front());
            if (acc) begin
                r.addr = addr;
                r.due  = cyc - 1 + lat;
                pend.push_back(r);
            end
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus_valid     = 1'b1;
            bus_read_data = mem_word(pend[0].addr);
        end else begin
            bus_valid     = 1'b0;
            bus_read_data = '0;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = '0;
        bus_wait_req = 1'b0;
        repeat (n) tick();
        reset   = 1'b0;
        acc_cnt = 0;
        pop_cnt = 0;
        #1;
    endtask

    task automatic wait_inst(input int limit);
        waited = 0;
        while (!inst_valid && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = '0;
        bus_wait_req  = 1'b0;
        bus_valid     = 1'b0;
        bus_read_data = '0;
        inst_ready    = 1'b0;

        // 1: streaming with zero wait states
        lat = 1;
        inst_ready = 1'b1;
        do_reset(2);
        check_eq("t1_rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("t1_rst_addr", bus_address, RESET_PC);
        check_eq("t1_first_req", {31'd0, bus_read_enable}, 32'd1);
        repeat (2) tick();
        check_eq("t1_first_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("t1_first_pc", inst_pc, RESET_PC);
        repeat (10) tick();
        check_eq("t1_throughput", pop_cnt, 32'd10);

        // 2: decode stalled, queue fills to 4 then drains in order
        inst_ready = 1'b0;
        do_reset(2);
        repeat (8) tick();
        check_eq("t2_accepts", acc_cnt, 32'd4);
        check_eq("t2_req_off", {31'd0, bus_read_enable}, 32'd0);
        check_eq("t2_head_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("t2_head_pc", inst_pc, RESET_PC);
        inst_ready = 1'b1;
        repeat (12) tick();
        check_eq("t2_drain_pops", pop_cnt, 32'd12);

        // 3: wait states on the first request
        do_reset(2);
        bus_wait_req = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_hold_en", {31'd0, bus_read_enable}, 32'd1);
            check_eq("t3_hold_addr", bus_address, RESET_PC);
            tick();
        end
        check_eq("t3_no_accept", acc_cnt, 32'd0);
        bus_wait_req = 1'b0;
        check_eq("t3_accept_addr", bus_address, RESET_PC);
        tick();
        check_eq("t3_next_addr", bus_address, RESET_PC + 32'd4);
        check_eq("t3_accepts", acc_cnt, 32'd1);

        // 4: latency 3, redirect with two reads in flight
        lat = 3;
        do_reset(2);
        repeat (2) tick();
        check_eq("t4_credit_stall", {31'd0, bus_read_enable}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h00400103;
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t4_r1_en", {31'd0, bus_read_enable}, 32'd0);
        check_eq("t4_r1_addr", bus_address, 32'h00400100);
        check_eq("t4_r1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check_eq("t4_r2_en", {31'd0, bus_read_enable}, 32'd1);
        check_eq("t4_r2_addr", bus_address, 32'h00400100);
        wait_inst(20);
        check_eq("t4_wait_cycles", waited, 32'd4);
        check_eq("t4_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("t4_pc", inst_pc, 32'h00400100);
        check_eq("t4_inst", inst, 32'h00100040);

        // 5: redirect coinciding with a response and a pop
        lat = 1;
        do_reset(2);
        repeat (6) tick();
        check_eq("t5_pre_bus_valid", {31'd0, bus_valid}, 32'd1);
        check_eq("t5_pre_inst_valid", {31'd0, inst_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h00400200;
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t5_flushed", {31'd0, inst_valid}, 32'd0);
        check_eq("t5_new_en", {31'd0, bus_read_enable}, 32'd1);
        check_eq("t5_new_addr", bus_address, 32'h00400200);
        wait_inst(20);
        check_eq("t5_wait_cycles", waited, 32'd2);
        check_eq("t5_pc", inst_pc, 32'h00400200);
        check_eq("t5_inst", inst, 32'h00100080);
        repeat (3) tick();

        // 6: reset with occupancy 3 and one read outstanding
        inst_ready = 1'b0;
        do_reset(2);
        repeat (4) tick();
        check_eq("t6_pre_valid", {31'd0, inst_valid}, 32'd1);
        check_eq("t6_pre_bus_valid", {31'd0, bus_valid}, 32'd1);
        check_eq("t6_pre_addr", bus_address, RESET_PC + 32'd16);
        reset = 1'b1;
        tick();
        check_eq("t6_rst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("t6_rst_addr", bus_address, RESET_PC);
        check_eq("t6_rst_en", {31'd0, bus_read_enable}, 32'd0);
        reset = 1'b0;
        inst_ready = 1'b1;
        #1;
        check_eq("t6_resume_en", {31'd0, bus_read_enable}, 32'd1);
        check_eq("t6_resume_addr", bus_address, RESET_PC);
        wait_inst(20);
        check_eq("t6_resume_pc", inst_pc, RESET_PC);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
